// File: rtl/add_pkg.sv
// Types and constants shared by the adder stage and the frame accumulator.
package add_pkg;

   localparam int OPND_W = 8;
   localparam int SUM_W  = OPND_W + 1;

   typedef enum logic {
      ACC  = 1'b0,
      HOLD = 1'b1
   } state_t;

   // Counter must hold values 0..n_samples.
   function automatic int cnt_width(input int n_samples);
      return (n_samples < 1) ? 1 : $clog2(n_samples + 1);
   endfunction

endpackage

// File: rtl/add_accum_frame_counter.sv
// Modulo-N beat counter; done flags the beat that completes a frame.
module frame_counter
   import add_pkg::*;
#(
   parameter int N = 4,
   parameter int W = cnt_width(N)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   output logic done
);

   localparam logic [W-1:0] LAST = W'(N - 1);

   logic [W-1:0] cnt;
   logic [W-1:0] base;

   // A clear in the same cycle as inc restarts the count from zero first.
   assign base = clr ? '0 : cnt;
   assign done = inc && (base == LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (done) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= base + W'(1);
      end else begin
         cnt <= base;
      end
   end

endmodule

// File: rtl/add_accum.sv
// Accumulates N_SAMPLES adder sums per frame and presents the total with a
// sticky overflow flag on a valid/ready port.
//
//   state | meaning
//   ------+-------------------------------------------------
//   ACC   | collecting sums, in_ready high
//   HOLD  | frame total presented, waiting for out handshake
module add_accum
   import add_pkg::*;
#(
   parameter int N_SAMPLES = 4,
   parameter int ACC_W     = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SUM_W-1:0] in_sum,
   input  logic             clear,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic             out_ovf
);

   localparam int CNT_W = cnt_width(N_SAMPLES);

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic             ovf;

   logic             beat;
   logic             hand;
   logic             clr_frame;
   logic             done;
   logic [ACC_W-1:0] acc_base;
   logic             ovf_base;
   logic [ACC_W-1:0] sum_ext;
   logic [ACC_W:0]   sum;

   assign in_ready  = rst_n && (state == ACC);
   assign out_valid = rst_n && (state == HOLD);
   assign beat      = in_valid && in_ready;
   assign hand      = out_valid && out_ready;

   // A clear arriving while a result is presented is dropped.
   assign clr_frame = clear && (state == ACC);

   assign acc_base = clr_frame ? '0 : acc;
   assign ovf_base = clr_frame ? 1'b0 : ovf;
   assign sum_ext  = ACC_W'(in_sum);
   assign sum      = {1'b0, acc_base} + {1'b0, sum_ext};

   frame_counter #(
      .N (N_SAMPLES),
      .W (CNT_W)
   ) u_frame_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (beat),
      .clr   (clr_frame),
      .done  (done)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ACC;
         acc   <= '0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            ACC: begin
               if (beat) begin
                  acc <= sum[ACC_W-1:0];
                  ovf <= ovf_base | sum[ACC_W];
                  if (done) begin
                     state <= HOLD;
                  end
               end else if (clr_frame) begin
                  acc <= '0;
                  ovf <= 1'b0;
               end
            end
            HOLD: begin
               if (hand) begin
                  acc   <= '0;
                  ovf   <= 1'b0;
                  state <= ACC;
               end
            end
            default: begin
               state <= ACC;
            end
         endcase
      end
   end

   assign out_acc = acc;
   assign out_ovf = ovf;

endmodule

// File: tb/tb_add_accum.sv
// Directed bench for add_accum: defaults, a narrow overflowing instance and
// a single-sample streaming instance.
module tb_add_accum;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;

   // dut0: N_SAMPLES=4, ACC_W=12
   logic        in_valid0 = 0, in_ready0, clear0 = 0, out_valid0, out_ready0 = 1, out_ovf0;
   logic [8:0]  in_sum0 = '0;
   logic [11:0] out_acc0;
   // dut1: N_SAMPLES=3, ACC_W=10
   logic        in_valid1 = 0, in_ready1, clear1 = 0, out_valid1, out_ready1 = 1, out_ovf1;
   logic [8:0]  in_sum1 = '0;
   logic [9:0]  out_acc1;
   // dut2: N_SAMPLES=1, ACC_W=12
   logic        in_valid2 = 0, in_ready2, clear2 = 0, out_valid2, out_ready2 = 1, out_ovf2;
   logic [8:0]  in_sum2 = '0;
   logic [11:0] out_acc2;

   add_accum #(.N_SAMPLES(4), .ACC_W(12)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0), .in_sum(in_sum0),
      .clear(clear0), .out_valid(out_valid0), .out_ready(out_ready0), .out_acc(out_acc0),
      .out_ovf(out_ovf0));

   add_accum #(.N_SAMPLES(3), .ACC_W(10)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .in_sum(in_sum1),
      .clear(clear1), .out_valid(out_valid1), .out_ready(out_ready1), .out_acc(out_acc1),
      .out_ovf(out_ovf1));

   add_accum #(.N_SAMPLES(1), .ACC_W(12)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .in_sum(in_sum2),
      .clear(clear2), .out_valid(out_valid2), .out_ready(out_ready2), .out_acc(out_acc2),
      .out_ovf(out_ovf2));

   // Inputs change and outputs are sampled on the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic beat0(input logic [8:0] v);
      in_valid0 = 1'b1;
      in_sum0   = v;
      tick();
      in_valid0 = 1'b0;
   endtask

   task automatic beat1(input logic [8:0] v);
      in_valid1 = 1'b1;
      in_sum1   = v;
      tick();
      in_valid1 = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      vectors++; if (in_ready0 !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready0); end
      vectors++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid0); end
      vectors++; if (out_acc0 !== 12'd0) begin errors++; $display("FAIL reset_out_acc got=%0d exp=0", out_acc0); end
      vectors++; if (out_ovf0 !== 1'b0) begin errors++; $display("FAIL reset_out_ovf got=%b exp=0", out_ovf0); end
      vectors++; if (in_ready2 !== 1'b0) begin errors++; $display("FAIL reset_in_ready2 got=%b exp=0", in_ready2); end
      rst_n = 1'b1;
      tick();
      vectors++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready0); end
   endtask

   task automatic test_basic_frame();
      logic [8:0] vals [4] = '{9'd10, 9'd20, 9'd30, 9'd40};
      out_ready0 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         vectors++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL basic_in_ready[%0d] got=%b exp=1", i, in_ready0); end
         beat0(vals[i]);
         if (i < 3) begin
            vectors++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL basic_early_valid[%0d] got=%b exp=0", i, out_valid0); end
         end
      end
      vectors++; if (out_valid0 !== 1'b1) begin errors++; $display("FAIL basic_out_valid got=%b exp=1", out_valid0); end
      vectors++; if (out_acc0 !== 12'd100) begin errors++; $display("FAIL basic_out_acc got=%0d exp=100", out_acc0); end
      vectors++; if (out_ovf0 !== 1'b0) begin errors++; $display("FAIL basic_out_ovf got=%b exp=0", out_ovf0); end
      vectors++; if (in_ready0 !== 1'b0) begin errors++; $display("FAIL basic_hold_in_ready got=%b exp=0", in_ready0); end
      tick();
      vectors++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL basic_after_in_ready got=%b exp=1", in_ready0); end
      vectors++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL basic_after_valid got=%b exp=0", out_valid0); end
   endtask

   task automatic test_overflow();
      out_ready1 = 1'b1;
      beat1(9'd511); beat1(9'd511); beat1(9'd511);
      vectors++; if (out_valid1 !== 1'b1) begin errors++; $display("FAIL ovf_out_valid got=%b exp=1", out_valid1); end
      vectors++; if (out_acc1 !== 10'd509) begin errors++; $display("FAIL ovf_out_acc got=%0d exp=509", out_acc1); end
      vectors++; if (out_ovf1 !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", out_ovf1); end
      tick();
      beat1(9'd1); beat1(9'd1); beat1(9'd1);
      vectors++; if (out_valid1 !== 1'b1) begin errors++; $display("FAIL ovf2_out_valid got=%b exp=1", out_valid1); end
      vectors++; if (out_acc1 !== 10'd3) begin errors++; $display("FAIL ovf2_out_acc got=%0d exp=3", out_acc1); end
      vectors++; if (out_ovf1 !== 1'b0) begin errors++; $display("FAIL ovf2_flag got=%b exp=0", out_ovf1); end
      tick();
   endtask

   task automatic test_backpressure();
      out_ready0 = 1'b0;
      beat0(9'd1); beat0(9'd2); beat0(9'd3); beat0(9'd4);
      in_valid0 = 1'b1;
      in_sum0   = 9'd50;
      for (int i = 0; i < 5; i++) begin
         vectors++; if (in_ready0 !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready0); end
         vectors++; if (out_valid0 !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d] got=%b exp=1", i, out_valid0); end
         vectors++; if (out_acc0 !== 12'd10) begin errors++; $display("FAIL bp_out_acc[%0d] got=%0d exp=10", i, out_acc0); end
         tick();
      end
      in_valid0  = 1'b0;
      out_ready0 = 1'b1;
      tick();
      vectors++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL bp_release_valid got=%b exp=0", out_valid0); end
      vectors++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready0); end
      beat0(9'd6); beat0(9'd6); beat0(9'd6); beat0(9'd6);
      vectors++; if (out_acc0 !== 12'd24) begin errors++; $display("FAIL bp_next_acc got=%0d exp=24", out_acc0); end
      vectors++; if (out_valid0 !== 1'b1) begin errors++; $display("FAIL bp_next_valid got=%b exp=1", out_valid0); end
      tick();
   endtask

   task automatic test_clear();
      out_ready0 = 1'b1;
      beat0(9'd3); beat0(9'd4);
      clear0 = 1'b1;
      tick();
      clear0 = 1'b0;
      vectors++; if (out_acc0 !== 12'd0) begin errors++; $display("FAIL clr_alone_acc got=%0d exp=0", out_acc0); end
      beat0(9'd5); beat0(9'd5); beat0(9'd5); beat0(9'd5);
      vectors++; if (out_valid0 !== 1'b1) begin errors++; $display("FAIL clr_alone_valid got=%b exp=1", out_valid0); end
      vectors++; if (out_acc0 !== 12'd20) begin errors++; $display("FAIL clr_alone_total got=%0d exp=20", out_acc0); end
      tick();
      beat0(9'd9); beat0(9'd9);
      clear0 = 1'b1;
      beat0(9'd7);
      clear0 = 1'b0;
      vectors++; if (out_acc0 !== 12'd7) begin errors++; $display("FAIL clr_beat_acc got=%0d exp=7", out_acc0); end
      beat0(9'd1); beat0(9'd1);
      vectors++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL clr_beat_early got=%b exp=0", out_valid0); end
      beat0(9'd1);
      vectors++; if (out_valid0 !== 1'b1) begin errors++; $display("FAIL clr_beat_valid got=%b exp=1", out_valid0); end
      vectors++; if (out_acc0 !== 12'd10) begin errors++; $display("FAIL clr_beat_total got=%0d exp=10", out_acc0); end
      tick();
      // clear while a result is held must not drop it
      out_ready0 = 1'b0;
      beat0(9'd1); beat0(9'd1); beat0(9'd1); beat0(9'd1);
      clear0 = 1'b1;
      tick();
      clear0 = 1'b0;
      vectors++; if (out_valid0 !== 1'b1) begin errors++; $display("FAIL clr_hold_valid got=%b exp=1", out_valid0); end
      vectors++; if (out_acc0 !== 12'd4) begin errors++; $display("FAIL clr_hold_acc got=%0d exp=4", out_acc0); end
      out_ready0 = 1'b1;
      tick();
   endtask

   task automatic test_midframe_reset();
      out_ready0 = 1'b1;
      beat0(9'd8); beat0(9'd8); beat0(9'd8);
      rst_n     = 1'b0;
      in_valid0 = 1'b1;
      in_sum0   = 9'd8;
      #1;
      vectors++; if (in_ready0 !== 1'b0) begin errors++; $display("FAIL rst_mid_in_ready got=%b exp=0", in_ready0); end
      tick();
      vectors++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b exp=0", out_valid0); end
      vectors++; if (out_acc0 !== 12'd0) begin errors++; $display("FAIL rst_mid_acc got=%0d exp=0", out_acc0); end
      rst_n     = 1'b1;
      in_valid0 = 1'b0;
      beat0(9'd2); beat0(9'd2); beat0(9'd2);
      vectors++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL rst_mid_early got=%b exp=0", out_valid0); end
      beat0(9'd2);
      vectors++; if (out_valid0 !== 1'b1) begin errors++; $display("FAIL rst_mid_next_valid got=%b exp=1", out_valid0); end
      vectors++; if (out_acc0 !== 12'd8) begin errors++; $display("FAIL rst_mid_next_acc got=%0d exp=8", out_acc0); end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [8:0] vals [4] = '{9'd5, 9'd100, 9'd300, 9'd511};
      out_ready2 = 1'b1;
      in_valid2  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_sum2 = vals[i];
         tick();
         vectors++; if (out_valid2 !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i, out_valid2); end
         vectors++; if (out_acc2 !== {3'b000, vals[i]}) begin errors++; $display("FAIL b2b_acc[%0d] got=%0d exp=%0d", i, out_acc2, vals[i]); end
         vectors++; if (in_ready2 !== 1'b0) begin errors++; $display("FAIL b2b_in_ready[%0d] got=%b exp=0", i, in_ready2); end
         in_sum2 = 9'h1AA;
         tick();
         vectors++; if (out_valid2 !== 1'b0) begin errors++; $display("FAIL b2b_gap[%0d] got=%b exp=0", i, out_valid2); end
      end
      in_valid2 = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic_frame();
      test_overflow();
      test_backpressure();
      test_clear();
      test_midframe_reset();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
